// File: rtl/mem_stream_arb_pkg.sv
// Shared helpers and defaults for the memory stream arbiter.
// Optional feature macro: MEM_STREAM_ARB_PRIO0_EN (strict priority for requester 0).
package mem_stream_arb_pkg;

    localparam int unsigned DefaultNumReq         = 4;
    localparam int unsigned DefaultMaxOutstanding = 2;

    // Index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mem_stream_arb_id_fifo.sv
// In-order FIFO of requester indices owning the outstanding memory transactions.
// Non-fall-through; push and pop may occur in the same cycle, including at full.
module mem_stream_arb_id_fifo
    import mem_stream_arb_pkg::*;
#(
    parameter int unsigned Depth = DefaultMaxOutstanding,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_reg [Depth];
    logic [PtrW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]  count_reg;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CntW'(Depth));
    assign empty   = (count_reg == '0);
    assign head    = mem_reg[rd_ptr_reg];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_arbiter.sv
// Round-robin arbiter sharing one in-order memory request/response stream among NumReq requesters.
// Define MEM_STREAM_ARB_PRIO0_EN to give requester 0 strict priority over the rotation.
module mem_stream_arbiter
    import mem_stream_arb_pkg::*;
#(
    parameter int unsigned NumReq         = DefaultNumReq,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
    parameter type         mem_req_t      = logic,
    parameter type         mem_resp_t     = logic
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  mem_req_t          req_i [NumReq],
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_ready_o,
    output mem_resp_t         resp_o [NumReq],
    output logic [NumReq-1:0] resp_valid_o,
    input  logic [NumReq-1:0] resp_ready_i,
    output mem_req_t          mem_req_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    input  mem_resp_t         mem_resp_i,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o
);

    localparam int unsigned IdxW = idx_width(NumReq);
    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_ptr_q, rr_ptr_next;
    idx_t lock_idx_q, lock_idx_next;
    logic lock_q, lock_next;
    idx_t grant, head, scan;
    logic cand_valid;
    logic fifo_full, fifo_empty, fifo_full_eff;
    logic req_hs, resp_hs;

    always_comb begin
        grant      = rr_ptr_q;
        cand_valid = 1'b0;
        scan       = '0;
        if (lock_q) begin
            // Held grant keeps the payload stable while memory backpressures.
            grant      = lock_idx_q;
            cand_valid = req_valid_i[lock_idx_q];
`ifdef MEM_STREAM_ARB_PRIO0_EN
        end else if (req_valid_i[0]) begin
            grant      = '0;
            cand_valid = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NumReq - 1; k++) begin
                scan = idx_t'(1 + ((32'((rr_ptr_q == '0) ? idx_t'(1) : rr_ptr_q) - 1 + k) % (NumReq - 1)));
                if (!cand_valid && req_valid_i[scan]) begin
                    grant      = scan;
                    cand_valid = 1'b1;
                end
            end
        end
`else
        end else begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                scan = idx_t'((32'(rr_ptr_q) + k) % NumReq);
                if (!cand_valid && req_valid_i[scan]) begin
                    grant      = scan;
                    cand_valid = 1'b1;
                end
            end
        end
`endif
    end

    assign fifo_full_eff    = fifo_full && !resp_hs;
    assign mem_req_valid_o  = cand_valid && !fifo_full_eff && !rst_i;
    assign mem_req_o        = req_i[grant];
    assign req_hs           = mem_req_valid_o && mem_req_ready_i;
    assign mem_resp_ready_o = resp_ready_i[head] && !fifo_empty && !rst_i;
    assign resp_hs          = mem_resp_valid_i && mem_resp_ready_o;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_lane
        assign resp_o[gi]       = mem_resp_i;
        assign resp_valid_o[gi] = mem_resp_valid_i && !fifo_empty && !rst_i && (head == idx_t'(gi));
        assign req_ready_o[gi]  = mem_req_ready_i && !fifo_full_eff && !rst_i && (grant == idx_t'(gi));
    end

    always_comb begin
        rr_ptr_next   = rr_ptr_q;
        lock_next     = lock_q;
        lock_idx_next = lock_idx_q;
        if (req_hs) begin
            lock_next = 1'b0;
`ifdef MEM_STREAM_ARB_PRIO0_EN
            // Requester 0 is outside the rotation; its grants leave the pointer alone.
            if (grant != '0) begin
                rr_ptr_next = idx_t'(rr_next(32'(grant), NumReq));
                if (rr_ptr_next == '0) begin
                    rr_ptr_next = idx_t'(1);
                end
            end
`else
            rr_ptr_next = idx_t'(rr_next(32'(grant), NumReq));
`endif
        end else if (mem_req_valid_o && !mem_req_ready_i) begin
            lock_next     = 1'b1;
            lock_idx_next = grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_next;
            lock_q     <= lock_next;
            lock_idx_q <= lock_idx_next;
        end
    end

    mem_stream_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (req_hs),
        .push_data (grant),
        .pop       (resp_hs),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    resp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_resp_valid_i |-> !fifo_empty);

    req_valid_dropped: assert property (@(posedge clk_i) disable iff (rst_i)
        lock_q |-> req_valid_i[lock_idx_q]);

endmodule

// File: tb/tb_mem_stream_arbiter.sv
// Scoreboard bench for mem_stream_arbiter: stimulus queues expected handshakes, a negedge monitor checks them.
module tb_mem_stream_arbiter;

    localparam int N = 4;
    typedef logic [7:0] byte_t;
    typedef struct {
        int    idx;
        byte_t data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    byte_t         req [N];
    logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
    byte_t         resp [N];
    byte_t         mem_req, mem_resp;
    logic          mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_req_q[$];
    exp_t exp_resp_q[$];
    int   lanes[4];

    always #5 clk = ~clk;

    mem_stream_arbiter #(
        .NumReq         (N),
        .MaxOutstanding (2),
        .mem_req_t      (byte_t),
        .mem_resp_t     (byte_t)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .resp_o           (resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .mem_req_o        (mem_req),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_resp_i       (mem_resp),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_ready_o (mem_resp_ready)
    );

    function automatic byte_t pay(input int i);
        return byte_t'((i + 1) * 16);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic rv,
                         input byte_t rd, input logic [N-1:0] rr);
        req_valid      = v;
        mem_req_ready  = rdy;
        mem_resp_valid = rv;
        mem_resp       = rd;
        resp_ready     = rr;
    endtask

    task automatic exp_req(input int i);
        exp_t e;
        e.idx  = i;
        e.data = pay(i);
        exp_req_q.push_back(e);
    endtask

    task automatic exp_resp(input int i, input byte_t d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        exp_resp_q.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
        chk({tag, "_mem_resp_ready"}, 32'(mem_resp_ready), 0);
    endtask

    // Monitor: every handshake the DUT performs must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_unexpected: got grant 0x%0h data 0x%0h, expected no request", req_ready, mem_req);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_grant", 32'(req_ready), 32'(1) << e.idx);
                    chk("req_data", 32'(mem_req), 32'(e.data));
                    $display("req  lane %0d data 0x%0h", e.idx, mem_req);
                end
            end
            if (mem_resp_valid && mem_resp_ready) begin
                if (exp_resp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got lanes 0x%0h, expected no response", resp_valid);
                end else begin
                    e = exp_resp_q.pop_front();
                    chk("resp_lane", 32'(resp_valid), 32'(1) << e.idx);
                    chk("resp_data", 32'(resp[e.idx]), 32'(e.data));
                    $display("resp lane %0d data 0x%0h", e.idx, resp[e.idx]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) req[i] = pay(i);
        rst = 1'b1;
        drive(4'hF, 1'b1, 1'b1, 8'hEE, 4'hF);
        repeat (2) begin
            settle();
            chk_all_idle("reset");
            next_cycle();
        end
        rst = 1'b0;
        drive(4'h0, 1'b1, 1'b0, 8'h00, 4'hF);

        // Rotation with responses one cycle behind each grant.
        for (int c = 0; c <= 8; c++) begin
            drive((c < 8) ? 4'hF : 4'h0, 1'b1, c >= 1, byte_t'(8'hC0 + c), 4'hF);
            if (c < 8) exp_req(c % 4);
            if (c >= 1) exp_resp((c - 1) % 4, byte_t'(8'hC0 + c));
            next_cycle();
        end

        // Backpressure lock on requester 1; requester 0 rising must not steal the grant.
        for (int c = 0; c < 3; c++) begin
            drive((c == 2) ? 4'b1011 : 4'b1010, 1'b0, 1'b0, 8'h00, 4'hF);
            settle();
            chk("bp_valid", 32'(mem_req_valid), 1);
            chk("bp_payload", 32'(mem_req), 32'h20);
            chk("bp_ready", 32'(req_ready), 0);
            next_cycle();
        end
        drive(4'b1011, 1'b1, 1'b0, 8'h00, 4'hF);
        exp_req(1);
        settle();
        chk("bp_release_payload", 32'(mem_req), 32'h20);
        next_cycle();
        drive(4'b1001, 1'b1, 1'b0, 8'h00, 4'hF);
        exp_req(3);
        next_cycle();

        // Outstanding limit: two IDs in flight, no further issue until a response pops.
        repeat (2) begin
            drive(4'hF, 1'b1, 1'b0, 8'h00, 4'hF);
            settle();
            chk("full_valid", 32'(mem_req_valid), 0);
            chk("full_ready", 32'(req_ready), 0);
            next_cycle();
        end
        drive(4'hF, 1'b1, 1'b1, 8'h61, 4'hF);
        exp_resp(1, 8'h61);
        exp_req(0);
        settle();
        chk("pop_push_valid", 32'(mem_req_valid), 1);
        next_cycle();
        drive(4'h0, 1'b1, 1'b1, 8'h63, 4'hF);
        exp_resp(3, 8'h63);
        next_cycle();
        drive(4'h0, 1'b1, 1'b1, 8'h60, 4'hF);
        exp_resp(0, 8'h60);
        next_cycle();

        // Response stall with requester 2 at the head.
        drive(4'b0100, 1'b1, 1'b0, 8'h00, 4'hF);
        exp_req(2);
        next_cycle();
        repeat (2) begin
            drive(4'h0, 1'b1, 1'b1, 8'h62, 4'b1011);
            settle();
            chk("stall_mem_resp_ready", 32'(mem_resp_ready), 0);
            chk("stall_lane", 32'(resp_valid), 32'b0100);
            next_cycle();
        end
        drive(4'h0, 1'b1, 1'b1, 8'h62, 4'hF);
        exp_resp(2, 8'h62);
        next_cycle();
        drive(4'h0, 1'b1, 1'b0, 8'h00, 4'hF);
        settle();
        chk("stall_drained", 32'(mem_resp_ready), 0);
        next_cycle();

        // Requesters 0 and 2 continuously valid.
`ifdef MEM_STREAM_ARB_PRIO0_EN
        lanes = '{0, 0, 0, 0};
`else
        lanes = '{0, 2, 0, 2};
`endif
        for (int p = 0; p <= 4; p++) begin
            drive((p < 4) ? 4'b0101 : 4'h0, 1'b1, p >= 1, byte_t'(8'h70 + p), 4'hF);
            if (p < 4) exp_req(lanes[p]);
            if (p >= 1) exp_resp(lanes[p - 1], byte_t'(8'h70 + p));
            next_cycle();
        end

        // Reset with two IDs outstanding.
        drive(4'hF, 1'b1, 1'b0, 8'h00, 4'hF);
        exp_req(3);
        next_cycle();
        exp_req(0);
        next_cycle();
        rst = 1'b1;
        drive(4'hF, 1'b1, 1'b1, 8'hEE, 4'hF);
        settle();
        chk_all_idle("midrst");
        next_cycle();
        rst = 1'b0;
        drive(4'hF, 1'b1, 1'b0, 8'h00, 4'hF);
        exp_req(0);
        next_cycle();
        drive(4'h0, 1'b1, 1'b1, 8'h90, 4'hF);
        exp_resp(0, 8'h90);
        next_cycle();
        drive(4'h0, 1'b1, 1'b0, 8'h00, 4'hF);
        settle();
        chk("post_rst_empty", 32'(mem_resp_ready), 0);
        next_cycle();

        chk("req_queue_drained", 32'(exp_req_q.size()), 0);
        chk("resp_queue_drained", 32'(exp_resp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
